// File: rtl/tl_a_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tl_a_rr_arbiter
//   Arbitrates NUM_IN TileLink-style A-channel request streams onto a single
//   downstream port through one registered output stage. Grant policy is
//   fixed priority (RR_MODE=0, lowest index wins) or round-robin (RR_MODE=1).
//   A multi-beat Put message locks the grant to its source until its last
//   beat has been accepted.
//
// Ports
//   clock                sole clock
//   reset                asynchronous active-low reset
//   io_in_valid/ready    per-channel handshake (ready is combinational)
//   io_in_bits_*         packed per-channel opcode/size/address/data
//   io_out_ready         downstream accept
//   io_out_valid/bits_*  registered output beat
//   io_out_chosen        source channel of the current output beat
// ----------------------------------------------------------------------------
module tl_a_rr_arbiter #(
    parameter int NUM_IN  = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SIZE_W  = 4,
    parameter int RR_MODE = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_IN-1:0]          io_in_valid,
    output logic [NUM_IN-1:0]          io_in_ready,
    input  logic [3*NUM_IN-1:0]        io_in_bits_opcode,
    input  logic [SIZE_W*NUM_IN-1:0]   io_in_bits_size,
    input  logic [ADDR_W*NUM_IN-1:0]   io_in_bits_address,
    input  logic [DATA_W*NUM_IN-1:0]   io_in_bits_data,
    input  logic                       io_out_ready,
    output logic                       io_out_valid,
    output logic [2:0]                 io_out_bits_opcode,
    output logic [SIZE_W-1:0]          io_out_bits_size,
    output logic [ADDR_W-1:0]          io_out_bits_address,
    output logic [DATA_W-1:0]          io_out_bits_data,
    output logic [$clog2(NUM_IN)-1:0]  io_out_chosen
);

    localparam int CH_W          = $clog2(NUM_IN);
    localparam int LOG_BPB       = $clog2(DATA_W / 8);
    localparam int MAX_LOG_BEATS = (2 ** SIZE_W) - 1 - LOG_BPB;
    localparam int CNT_W         = (MAX_LOG_BEATS > 0) ? MAX_LOG_BEATS : 1;

    // Output stage and arbitration state
    logic              out_valid_q, out_valid_d;
    logic [2:0]        out_opcode_q, out_opcode_d;
    logic [SIZE_W-1:0] out_size_q, out_size_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CH_W-1:0]   chosen_q, chosen_d;
    logic              lock_q, lock_d;
    logic [CH_W-1:0]   lock_id_q, lock_id_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [CH_W-1:0]   last_grant_q, last_grant_d;

    // Combinational arbitration signals
    logic              can_load_s;
    logic              any_valid_s;
    logic              fire_s;
    logic [CH_W-1:0]   grant_s;
    int                best_dist_s;
    logic [2:0]        sel_opcode_s;
    logic [SIZE_W-1:0] sel_size_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_data_s;
    logic              multi_beat_s;
    logic [CNT_W-1:0]  burst_len_m1_s;

    assign can_load_s  = ~out_valid_q | io_out_ready;
    assign any_valid_s = |io_in_valid;
    assign fire_s      = |(io_in_valid & io_in_ready);

    // Grant selection: lock owner, else round-robin distance from last grant, else lowest index
    always_comb begin
        grant_s     = '0;
        best_dist_s = NUM_IN;
        if (lock_q) begin
            grant_s = lock_id_q;
        end else if (RR_MODE != 0) begin
            // Distance 0 is the channel right after last_grant; smallest valid distance wins
            for (int i = 0; i < NUM_IN; i++) begin
                if (io_in_valid[i] &&
                    (((i + NUM_IN - int'(last_grant_q) - 1) % NUM_IN) < best_dist_s)) begin
                    best_dist_s = (i + NUM_IN - int'(last_grant_q) - 1) % NUM_IN;
                    grant_s     = CH_W'(i);
                end else begin
                end
            end
        end else begin
            for (int i = NUM_IN - 1; i >= 0; i--) begin
                if (io_in_valid[i]) begin
                    grant_s = CH_W'(i);
                end else begin
                end
            end
        end
    end

    // Ready goes only to the granted channel; it never looks at that channel's own valid
    always_comb begin
        io_in_ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            io_in_ready[i] = reset & can_load_s & any_valid_s & (grant_s == CH_W'(i));
        end
    end

    // Mux out the granted channel's request fields
    always_comb begin
        sel_opcode_s = '0;
        sel_size_s   = '0;
        sel_addr_s   = '0;
        sel_data_s   = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_s == CH_W'(i)) begin
                sel_opcode_s = io_in_bits_opcode[i*3 +: 3];
                sel_size_s   = io_in_bits_size[i*SIZE_W +: SIZE_W];
                sel_addr_s   = io_in_bits_address[i*ADDR_W +: ADDR_W];
                sel_data_s   = io_in_bits_data[i*DATA_W +: DATA_W];
            end else begin
            end
        end
    end

    // Put messages wider than one data beat become bursts of 2^size / bytes-per-beat.
    // At the largest size the shift wraps to zero, so subtracting one still yields all-ones.
    assign multi_beat_s   = ((sel_opcode_s == 3'd0) || (sel_opcode_s == 3'd1)) &&
                            (sel_size_s > SIZE_W'(LOG_BPB));
    assign burst_len_m1_s = (CNT_W'(1) << (sel_size_s - SIZE_W'(LOG_BPB))) - CNT_W'(1);

    // Next-state: load on fire, drain on handshake, maintain lock and round-robin pointer
    always_comb begin
        out_valid_d  = out_valid_q;
        out_opcode_d = out_opcode_q;
        out_size_d   = out_size_q;
        out_addr_d   = out_addr_q;
        out_data_d   = out_data_q;
        chosen_d     = chosen_q;
        lock_d       = lock_q;
        lock_id_d    = lock_id_q;
        beat_cnt_d   = beat_cnt_q;
        last_grant_d = last_grant_q;
        if (fire_s) begin
            out_valid_d  = 1'b1;
            out_opcode_d = sel_opcode_s;
            out_size_d   = sel_size_s;
            out_addr_d   = sel_addr_s;
            out_data_d   = sel_data_s;
            chosen_d     = grant_s;
            if (lock_q) begin
                // Continuation beat: count down; the beat taking the count to zero ends the lock
                beat_cnt_d = beat_cnt_q - CNT_W'(1);
                lock_d     = (beat_cnt_q != CNT_W'(1));
            end else begin
                last_grant_d = grant_s;
                if (multi_beat_s) begin
                    lock_d     = 1'b1;
                    lock_id_d  = grant_s;
                    beat_cnt_d = burst_len_m1_s;
                end else begin
                    lock_d = 1'b0;
                end
            end
        end else if (io_out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid_q  <= 1'b0;
            out_opcode_q <= 3'd0;
            out_size_q   <= '0;
            out_addr_q   <= '0;
            out_data_q   <= '0;
            chosen_q     <= '0;
            lock_q       <= 1'b0;
            lock_id_q    <= '0;
            beat_cnt_q   <= '0;
            last_grant_q <= CH_W'(NUM_IN - 1);
        end else begin
            out_valid_q  <= out_valid_d;
            out_opcode_q <= out_opcode_d;
            out_size_q   <= out_size_d;
            out_addr_q   <= out_addr_d;
            out_data_q   <= out_data_d;
            chosen_q     <= chosen_d;
            lock_q       <= lock_d;
            lock_id_q    <= lock_id_d;
            beat_cnt_q   <= beat_cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign io_out_valid        = out_valid_q;
    assign io_out_bits_opcode  = out_opcode_q;
    assign io_out_bits_size    = out_size_q;
    assign io_out_bits_address = out_addr_q;
    assign io_out_bits_data    = out_data_q;
    assign io_out_chosen       = chosen_q;

endmodule

// File: tb/tb_tl_a_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_tl_a_rr_arbiter
//   Two arbiters share one set of inputs: index 0 is round-robin, index 1 is
//   fixed priority. A transaction-level model tracks the expected output
//   register, the lock owner / remaining beats and the round-robin pointer.
// ----------------------------------------------------------------------------
module tb_tl_a_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic            clock;
    logic            reset;
    logic [N-1:0]    in_valid;
    logic [3*N-1:0]  in_op;
    logic [SW*N-1:0] in_size;
    logic [AW*N-1:0] in_addr;
    logic [DW*N-1:0] in_data;
    logic            out_ready;

    logic            o_valid  [2];
    logic [N-1:0]    o_ready  [2];
    logic [2:0]      o_op     [2];
    logic [SW-1:0]   o_size   [2];
    logic [AW-1:0]   o_addr   [2];
    logic [DW-1:0]   o_data   [2];
    logic [1:0]      o_chosen [2];

    int checks = 0;
    int errors = 0;

    // Reference model state, per instance
    bit          m_v      [2];
    logic [2:0]  m_op     [2];
    logic [3:0]  m_size   [2];
    logic [31:0] m_addr   [2];
    logic [31:0] m_data   [2];
    int          m_ch     [2];
    bit          m_lock   [2];
    int          m_lock_ch[2];
    int          m_rem    [2];
    int          m_last   [2];
    int          m_grant  [2];
    logic [N-1:0] m_ready [2];

    tl_a_rr_arbiter #(.NUM_IN(N), .ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW), .RR_MODE(1)) dut_rr (
        .clock(clock), .reset(reset),
        .io_in_valid(in_valid), .io_in_ready(o_ready[0]),
        .io_in_bits_opcode(in_op), .io_in_bits_size(in_size),
        .io_in_bits_address(in_addr), .io_in_bits_data(in_data),
        .io_out_ready(out_ready), .io_out_valid(o_valid[0]),
        .io_out_bits_opcode(o_op[0]), .io_out_bits_size(o_size[0]),
        .io_out_bits_address(o_addr[0]), .io_out_bits_data(o_data[0]),
        .io_out_chosen(o_chosen[0])
    );

    tl_a_rr_arbiter #(.NUM_IN(N), .ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW), .RR_MODE(0)) dut_fp (
        .clock(clock), .reset(reset),
        .io_in_valid(in_valid), .io_in_ready(o_ready[1]),
        .io_in_bits_opcode(in_op), .io_in_bits_size(in_size),
        .io_in_bits_address(in_addr), .io_in_bits_data(in_data),
        .io_out_ready(out_ready), .io_out_valid(o_valid[1]),
        .io_out_bits_opcode(o_op[1]), .io_out_bits_size(o_size[1]),
        .io_out_bits_address(o_addr[1]), .io_out_bits_data(o_data[1]),
        .io_out_chosen(o_chosen[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int beats_of(input int op, input int size);
        int bytes;
        bytes = 1 << size;
        if ((op == 0 || op == 1) && bytes > DW / 8) return bytes / (DW / 8);
        return 1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_v[m] = 1'b0; m_op[m] = 3'd0; m_size[m] = 4'd0;
            m_addr[m] = 32'd0; m_data[m] = 32'd0; m_ch[m] = 0;
            m_lock[m] = 1'b0; m_lock_ch[m] = 0; m_rem[m] = 0; m_last[m] = N - 1;
        end
    endtask

    // Who should be granted and which ready line should be high for the current inputs
    task automatic model_eval();
        for (int m = 0; m < 2; m++) begin
            m_grant[m] = -1;
            if (m_lock[m]) m_grant[m] = m_lock_ch[m];
            else if (m == 0) begin
                for (int k = 1; k <= N; k++)
                    if (m_grant[m] < 0 && in_valid[(m_last[m] + k) % N]) m_grant[m] = (m_last[m] + k) % N;
            end else begin
                for (int i = N - 1; i >= 0; i--) if (in_valid[i]) m_grant[m] = i;
            end
            m_ready[m] = '0;
            if (reset && (!m_v[m] || out_ready) && (in_valid != '0) && m_grant[m] >= 0)
                m_ready[m][m_grant[m]] = 1'b1;
        end
    endtask

    task automatic model_advance();
        int g;
        int b;
        for (int m = 0; m < 2; m++) begin
            g = m_grant[m];
            if (!reset) begin
                m_v[m] = 1'b0; m_op[m] = 3'd0; m_size[m] = 4'd0;
                m_addr[m] = 32'd0; m_data[m] = 32'd0; m_ch[m] = 0;
                m_lock[m] = 1'b0; m_rem[m] = 0; m_last[m] = N - 1;
            end else if (g >= 0 && m_ready[m][g] && in_valid[g]) begin
                m_v[m] = 1'b1;
                m_op[m] = in_op[g*3 +: 3];
                m_size[m] = in_size[g*SW +: SW];
                m_addr[m] = in_addr[g*AW +: AW];
                m_data[m] = in_data[g*DW +: DW];
                m_ch[m] = g;
                if (m_lock[m]) begin
                    m_rem[m] = m_rem[m] - 1;
                    if (m_rem[m] == 0) m_lock[m] = 1'b0;
                end else begin
                    m_last[m] = g;
                    b = beats_of(int'(in_op[g*3 +: 3]), int'(in_size[g*SW +: SW]));
                    if (b > 1) begin
                        m_lock[m] = 1'b1; m_lock_ch[m] = g; m_rem[m] = b - 1;
                    end
                end
            end else if (out_ready) begin
                m_v[m] = 1'b0;
            end
        end
    endtask

    // Advance model and DUT by one clock; returns 1 time unit after the edge
    task automatic tick();
        model_eval();
        model_advance();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ch(input int c, input bit v, input logic [2:0] op, input logic [3:0] sz,
                          input logic [31:0] a, input logic [31:0] d);
        in_valid[c]         = v;
        in_op[c*3 +: 3]     = op;
        in_size[c*SW +: SW] = sz;
        in_addr[c*AW +: AW] = a;
        in_data[c*DW +: DW] = d;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        out_ready = 1'b1;
        for (int c = 0; c < N; c++) set_ch(c, 1'b1, 3'd4, 4'd2, 32'h100 + c, 32'hA0 + c);
        reset = 1'b0;
        model_reset();
        repeat (3) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (o_valid[m] !== 1'b0 || o_ready[m] !== 4'b0000 || o_chosen[m] !== 2'd0 ||
                    o_addr[m] !== 32'd0 || o_data[m] !== 32'd0 || o_op[m] !== 3'd0) begin
                    errors++;
                    $display("FAIL reset_state inst%0d valid=%b ready=%b chosen=%0d addr=%h exp 0/0000/0/0",
                             m, o_valid[m], o_ready[m], o_chosen[m], o_addr[m]);
                end
            end
        end
        reset = 1'b1;
        #1;
        checks++;
        if (o_ready[0] !== 4'b0001) begin
            errors++; $display("FAIL reset_first_ready got %b exp 0001", o_ready[0]);
        end
        tick();
        checks++;
        if (o_valid[0] !== 1'b1 || o_chosen[0] !== 2'd0 || o_addr[0] !== 32'h100) begin
            errors++;
            $display("FAIL reset_first_grant valid=%b chosen=%0d addr=%h exp 1/0/100", o_valid[0], o_chosen[0], o_addr[0]);
        end
    endtask

    task automatic test_rr_fairness();
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < N; c++) set_ch(c, 1'b1, 3'd4, 4'd2, 32'h1000 * (c + 1), $urandom);
        for (int i = 0; i < 9; i++) begin
            #1;
            checks++;
            if (o_ready[0] !== 4'(1 << (i % 4))) begin
                errors++; $display("FAIL rr_ready cyc%0d got %b exp %b", i, o_ready[0], 4'(1 << (i % 4)));
            end
            tick();
            checks++;
            if (o_valid[0] !== 1'b1 || o_chosen[0] !== 2'(i % 4) || o_addr[0] !== 32'h1000 * ((i % 4) + 1)) begin
                errors++;
                $display("FAIL rr_chosen cyc%0d got %0d/%b exp %0d/1", i, o_chosen[0], o_valid[0], i % 4);
            end
        end
    endtask

    task automatic test_fixed();
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < N; c++) set_ch(c, (c == 1 || c == 3), 3'd4, 4'd2, 32'h40 * c, 32'h5 * c);
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (o_ready[1] !== 4'b0010) begin
                errors++; $display("FAIL fp_ready cyc%0d got %b exp 0010", i, o_ready[1]);
            end
            tick();
            checks++;
            if (o_chosen[1] !== 2'd1 || o_valid[1] !== 1'b1) begin
                errors++; $display("FAIL fp_chosen cyc%0d got %0d exp 1", i, o_chosen[1]);
            end
        end
    endtask

    task automatic test_burst_lock();
        int exp_seq[6] = '{2, 2, 2, 2, 3, 0};
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < N; c++) set_ch(c, (c == 1), 3'd4, 4'd2, 32'h10 * c, 32'h0);
        tick();
        set_ch(0, 1'b1, 3'd4, 4'd2, 32'h2000, 32'h11);
        set_ch(1, 1'b0, 3'd4, 4'd2, 32'h2100, 32'h22);
        set_ch(2, 1'b1, 3'd0, 4'd4, 32'h2200, 32'h33);
        set_ch(3, 1'b1, 3'd4, 4'd2, 32'h2300, 32'h44);
        for (int i = 0; i < 6; i++) begin
            #1;
            if (i < 4) begin
                checks++;
                if (o_ready[0] !== 4'b0100) begin
                    errors++; $display("FAIL burst_ready beat%0d got %b exp 0100", i, o_ready[0]);
                end
            end
            tick();
            checks++;
            if (o_chosen[0] !== 2'(exp_seq[i]) || o_valid[0] !== 1'b1) begin
                errors++; $display("FAIL burst_chosen cyc%0d got %0d exp %0d", i, o_chosen[0], exp_seq[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < N; c++) set_ch(c, 1'b1, 3'd4, 4'd2, 32'h3000 + c, 32'hD0 + c);
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (o_ready[0] !== 4'b0000) begin
                errors++; $display("FAIL bp_ready cyc%0d got %b exp 0000", i, o_ready[0]);
            end
            tick();
            checks++;
            if (o_valid[0] !== 1'b1 || o_chosen[0] !== 2'd0 || o_addr[0] !== 32'h3000 || o_data[0] !== 32'hD0) begin
                errors++;
                $display("FAIL bp_hold cyc%0d addr=%h data=%h exp 3000/d0", i, o_addr[0], o_data[0]);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (o_ready[0] !== 4'b0010) begin
            errors++; $display("FAIL bp_release_ready got %b exp 0010", o_ready[0]);
        end
        tick();
        checks++;
        if (o_valid[0] !== 1'b1 || o_chosen[0] !== 2'd1 || o_addr[0] !== 32'h3001) begin
            errors++; $display("FAIL bp_next got chosen %0d valid %b exp 1/1", o_chosen[0], o_valid[0]);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < N; c++) set_ch(c, (c == 1), 3'd4, 4'd2, 32'h50 * c, 32'h0);
        tick();
        set_ch(0, 1'b1, 3'd4, 4'd2, 32'h4000, 32'h1);
        set_ch(1, 1'b0, 3'd4, 4'd2, 32'h4100, 32'h2);
        set_ch(2, 1'b1, 3'd1, 4'd4, 32'h4200, 32'h3);
        tick();
        tick();
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (o_valid[0] !== 1'b0 || o_ready[0] !== 4'b0000) begin
            errors++; $display("FAIL midburst_reset valid=%b ready=%b exp 0/0000", o_valid[0], o_ready[0]);
        end
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (o_ready[0] !== 4'b0001) begin
            errors++; $display("FAIL midburst_after_ready got %b exp 0001", o_ready[0]);
        end
        tick();
        checks++;
        if (o_chosen[0] !== 2'd0 || o_addr[0] !== 32'h4000) begin
            errors++; $display("FAIL midburst_after_chosen got %0d exp 0", o_chosen[0]);
        end
    endtask

    task automatic test_random();
        logic [2:0] op;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < N; c++) begin
                case ($urandom_range(0, 3))
                    0: op = 3'd0;
                    1: op = 3'd1;
                    2: op = 3'd4;
                    default: op = 3'($urandom_range(0, 7));
                endcase
                set_ch(c, ($urandom_range(0, 9) < 6), op, 4'($urandom_range(0, 5)), $urandom, $urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            model_eval();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (o_ready[m] !== m_ready[m]) begin
                    errors++; $display("FAIL rand_ready inst%0d cyc%0d got %b exp %b", m, i, o_ready[m], m_ready[m]);
                end
            end
            tick();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (o_valid[m] !== m_v[m] || o_chosen[m] !== 2'(m_ch[m]) || o_op[m] !== m_op[m] ||
                    o_size[m] !== m_size[m] || o_addr[m] !== m_addr[m] || o_data[m] !== m_data[m]) begin
                    errors++;
                    $display("FAIL rand_out inst%0d cyc%0d got v%b ch%0d a=%h d=%h exp v%b ch%0d a=%h d=%h",
                             m, i, o_valid[m], o_chosen[m], o_addr[m], o_data[m],
                             m_v[m], m_ch[m], m_addr[m], m_data[m]);
                end
            end
        end
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = '0;
        in_op     = '0;
        in_size   = '0;
        in_addr   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();
        #2;
        test_reset();
        test_rr_fairness();
        test_fixed();
        test_burst_lock();
        test_backpressure();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tl_a_rr_arbiter.md
Name: tl_a_rr_arbiter

Overview:
- Parametrised N-channel arbiter for TileLink-style A-channel requests (opcode/size/address/data) feeding one downstream port, e.g. I-cache, D-cache and DMA masters onto the memory bus.
- Successor to the two-input fixed-priority combinational arbiter. Adds:
  - a configurable channel count;
  - selectable fixed-priority or round-robin policy;
  - a registered output stage;
  - grant locking for multi-beat Put bursts.

Parameters:
- NUM_IN, 4: number of request channels; legal range 2..16.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; must be a power of 2 and at least 8.
- SIZE_W, 4: width of the size field. Size is log2 of the byte count.
- RR_MODE, 1: 0 selects fixed priority (lowest index wins); 1 selects round-robin.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- io_in_valid  in  NUM_IN  per-channel request valid.
- io_in_ready  out  NUM_IN  per-channel accept.
- io_in_bits_opcode  in  3*NUM_IN  opcode of channel i at bits [3i+2:3i].
- io_in_bits_size  in  SIZE_W*NUM_IN  log2 of byte count, packed the same way.
- io_in_bits_address  in  ADDR_W*NUM_IN  packed addresses.
- io_in_bits_data  in  DATA_W*NUM_IN  packed data.
- io_out_ready  in  1  downstream accept.
- io_out_valid  out  1  registered output valid.
- io_out_bits_opcode  out  3  registered opcode.
- io_out_bits_size  out  SIZE_W  registered size.
- io_out_bits_address  out  ADDR_W  registered address.
- io_out_bits_data  out  DATA_W  registered data.
- io_out_chosen  out  clog2(NUM_IN)  index of the channel that sourced the current output beat.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - io_out_valid=0; all io_out_bits and io_out_chosen = 0.
  - lock=0, beat_cnt=0, last_grant=NUM_IN-1, so channel 0 is first in round-robin order.
  - io_in_ready is all 0 while reset is low.
  - Reset mid-burst drops the in-flight beats and lock; nothing is replayed.
- Output stage:
  - can_load = ~io_out_valid | io_out_ready.
  - Fire for channel g when io_in_valid[g] & io_in_ready[g]. On fire, the bits and chosen=g are registered and io_out_valid=1 on the next edge.
  - Latency is 1 cycle, with full throughput of 1 beat per cycle under continuous io_out_ready.
  - If can_load and nothing fires, io_out_valid clears on a downstream handshake.
  - Output bits stay stable while io_out_valid & ~io_out_ready.
- Grant, unlocked:
  - RR_MODE=0: grant = lowest-index valid channel.
  - RR_MODE=1: grant = first valid channel scanning last_grant+1, +2, … modulo NUM_IN.
  - io_in_ready[i] = can_load & (grant==i) & any valid; ready is 0 when no channel is valid.
  - Ready never depends on the channel's own valid beyond grant selection, i.e. no combinational loop to the input.
- Beat count:
  - beats = 2^size / (DATA_W/8) when opcode ∈ {0 PutFull, 1 PutPartial} and 2^size > DATA_W/8.
  - Otherwise beats = 1. This covers Get (4) and all other opcodes.
  - beat_cnt width is sufficient for 2^(2^SIZE_W-1) / (DATA_W/8).
- Lock:
  - When the first beat of a message with beats>1 fires: lock=1, lock_id=g, beat_cnt=beats-1.
  - While locked, grant=lock_id regardless of other valids or policy, and other channels' ready=0.
  - Each locked fire decrements beat_cnt. When the beat that brings beat_cnt to 0 fires, lock=0 on the next edge.
  - If the locked channel deasserts valid, the bus idles; lock is held and no other channel is granted.
- Round-robin pointer: last_grant updates to g only on a first-beat fire (unlocked fire). It is not updated on continuation beats.
- Simultaneous events: a downstream drain and a new load in the same cycle replace the register with no bubble.
- Size/opcode of a continuation beat are passed through unchecked; the count is fixed at the first beat.

Test Plan:
- Reset then idle: hold reset low 3 cycles with all valid=1 → io_out_valid=0 and io_in_ready=0000. After release, the first grant with RR_MODE=1 is channel 0.
- Round-robin fairness: NUM_IN=4, all valid, Get size=2, io_out_ready=1 → io_out_chosen sequence 0,1,2,3,0,…, one beat per cycle after 1-cycle latency.
- Fixed priority: RR_MODE=0, channels 1 and 3 valid continuously → io_out_chosen is always 1 and io_in_ready[3] stays 0.
- Burst lock: DATA_W=32, channel 2 PutFull size=4 (16 B, 4 beats), channel 0 valid with Get → 4 consecutive beats from channel 2, then the grant moves to channel 3→0 per round-robin order; channel 0 ready is 0 during the burst.
- Backpressure: io_out_ready=0 for 5 cycles with a beat held → io_out_bits unchanged, all io_in_ready=0. Raising ready drains the beat and loads the next in the same cycle.
- Reset mid-burst: assert reset after beat 2 of 4 → lock clears immediately. After release, channel 0 (a Get) is granted even with channel 2 still valid.
